// File: rtl/mem_initiator.sv
// mem_initiator: accepts one core load/store/fetch at a time and issues it as a
// single-cycle pulse on the memory bus. It waits for mem_ready, extracts and
// extends the returned lane, and answers with an error on timeout or reserved size.
// Optional macro MEM_INITIATOR_MISALIGN_TRAP_EN: misaligned half/word requests
// return an error without a bus access. Without it they are forced to natural
// alignment and issued normally.
module mem_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_instr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  // Last WAIT count value at which a missing ready becomes a timeout.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] count_reg;
  logic        write_reg, unsigned_reg;
  logic [1:0]  size_reg, lane_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        instr_reg;

  logic        accept, reject;
  logic [31:0] req_addr_eff, req_wdata_lane;
  logic [3:0]  req_wstrb;
  logic [7:0]  rbyte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign accept = (state_reg == IDLE) && req_valid;

  // Classify the incoming request and compute the address it will use on the bus
  always_comb begin
    req_addr_eff = req_addr;
`ifdef MEM_INITIATOR_MISALIGN_TRAP_EN
    reject = (req_size == 2'd3) ||
             (req_size == 2'd1 && req_addr[0]) ||
             (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
    reject = (req_size == 2'd3);
    if (req_size == 2'd1)
      req_addr_eff[0] = 1'b0;
    else if (req_size == 2'd2)
      req_addr_eff[1:0] = 2'b00;
`endif
  end

  // Byte strobes and lane-replicated store data for the incoming request
  always_comb begin
    req_wstrb      = 4'b1111;
    req_wdata_lane = req_wdata;
    case (req_size)
      2'd0: begin
        req_wstrb      = 4'b0001 << req_addr_eff[1:0];
        req_wdata_lane = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_wstrb      = 4'b0011 << {req_addr_eff[1], 1'b0};
        req_wdata_lane = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!req_write)
      req_wstrb = 4'b0000;
  end

  // Split the read word into byte lanes for lane selection
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Select the addressed lane and sign/zero-extend it
  always_comb begin
    byte_sel = rbyte[lane_reg];
    half_sel = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_reg)
      2'd0:    load_ext = {{24{~unsigned_reg & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{~unsigned_reg & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = reject ? RESP : REQ;
      REQ:  state_next = WAIT;
      WAIT: if (mem_ready || count_reg == WAIT_LIMIT) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    req_ready  = (state_reg == IDLE);
    mem_valid  = (state_reg == REQ);
    resp_valid = (state_reg == RESP);
  end

  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;
  assign mem_instr  = instr_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_wstrb  = wstrb_reg;

  // Request latching, timeout counting and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      write_reg    <= 1'b0;
      unsigned_reg <= 1'b0;
      size_reg     <= 2'd0;
      lane_reg     <= 2'd0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= 4'b0000;
      instr_reg    <= 1'b0;
    end else begin
      if (accept) begin
        write_reg    <= req_write;
        unsigned_reg <= req_unsigned;
        size_reg     <= req_size;
        lane_reg     <= req_addr_eff[1:0];
        rdata_reg    <= '0;
        err_reg      <= reject;
        if (!reject) begin
          addr_reg  <= req_addr_eff;
          wdata_reg <= req_wdata_lane;
          wstrb_reg <= req_wstrb;
          instr_reg <= req_instr;
        end
      end
      if (state_reg == REQ)
        count_reg <= '0;
      if (state_reg == WAIT) begin
        if (mem_ready) begin
          rdata_reg <= write_reg ? 32'd0 : load_ext;
          err_reg   <= 1'b0;
        end else if (count_reg == WAIT_LIMIT) begin
          rdata_reg <= '0;
          err_reg   <= 1'b1;
        end else begin
          count_reg <= count_reg + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
`timescale 1ns/1ps
module tb_mem_initiator;

  localparam int TO = 16;
`ifdef MEM_INITIATOR_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_instr, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  // Observations of the most recent transaction
  int          obs_pulses, obs_lat;
  logic        got, obs_acc, obs_stable, obs_instr, obs_err;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_wstrb;

  // Reference: what the bus and the response should look like for a request
  function automatic void model(input logic write, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] memd,
                                output logic rej, output logic [31:0] eaddr,
                                output logic [31:0] ewdata, output logic [31:0] erdata,
                                output logic [3:0] estrb);
    logic mis;
    int unsigned sh;
    logic [31:0] mask, v;
    mis = (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    rej = (size == 2'd3) || (TRAP && mis);
    eaddr = (size == 2'd1) ? (addr / 2) * 2 : (size == 2'd2) ? (addr / 4) * 4 : addr;
    sh = 0; mask = 32'hFFFF_FFFF;
    case (size)
      2'd0: begin
        ewdata = (wdata & 32'hFF) * 32'h0101_0101;
        estrb  = 4'(1 << (eaddr % 4));
        sh = (eaddr % 4) * 8; mask = 32'hFF;
      end
      2'd1: begin
        ewdata = (wdata & 32'hFFFF) * 32'h0001_0001;
        estrb  = (eaddr % 4 >= 2) ? 4'b1100 : 4'b0011;
        sh = (eaddr % 4 >= 2) ? 16 : 0; mask = 32'hFFFF;
      end
      default: begin
        ewdata = wdata;
        estrb  = 4'b1111;
      end
    endcase
    if (!write) estrb = 4'b0000;
    v = (memd >> sh) & mask;
    if (!uns && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
    erdata = (write || rej) ? 32'd0 : v;
  endfunction

  // Drive one request; memory answers 'delay' cycles after the pulse (<=0: never)
  task automatic run_txn(input logic instr, input logic write, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] memd, input int delay, input int hold);
    int pulse_cyc;
    pulse_cyc = -1; obs_pulses = 0; obs_lat = -1; got = 1'b0; obs_stable = 1'b1;
    obs_addr = 'x; obs_wdata = 'x; obs_wstrb = 'x; obs_instr = 1'bx;
    obs_acc = req_ready;
    req_valid = 1'b1; req_instr = instr; req_write = write; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    req_write = 1'($urandom); req_unsigned = 1'($urandom); req_instr = 1'($urandom);
    for (int c = 1; c < 200 && !got; c++) begin
      if (mem_valid) begin
        obs_pulses++;
        if (pulse_cyc < 0) begin
          pulse_cyc = c; obs_addr = mem_addr; obs_wdata = mem_wdata;
          obs_wstrb = mem_wstrb; obs_instr = mem_instr;
        end
      end
      if (resp_valid) begin
        got = 1'b1; obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err;
        mem_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          if (resp_valid !== 1'b1 || resp_rdata !== obs_rdata || resp_err !== obs_err)
            obs_stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
      end else begin
        if (delay > 0 && pulse_cyc >= 0 && c == pulse_cyc + delay) begin
          mem_ready = 1'b1; mem_rdata = memd;
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom;
        end
        @(posedge clk); #1;
      end
    end
    mem_ready = 1'b0;
    $display("txn w=%0b size=%0d addr=%h -> pulses=%0d lat=%0d rdata=%h err=%0b",
             write, size, addr, obs_pulses, obs_lat, obs_rdata, obs_err);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    req_instr = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_err !== 1'b0 || resp_rdata !== 32'd0) begin bad++; $display("FAIL reset_resp: got err=%b rdata=%h want 0/0", resp_err, resp_rdata); end
    total++; if (mem_valid !== 1'b0 || mem_instr !== 1'b0) begin bad++; $display("FAIL reset_mem_ctl: got valid=%b instr=%b want 0/0", mem_valid, mem_instr); end
    total++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0) begin bad++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h wstrb=%b want 0", mem_addr, mem_wdata, mem_wstrb); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_load;
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 0);
    total++; if (obs_acc !== 1'b1) begin bad++; $display("FAIL wl_ready: got %b want 1", obs_acc); end
    total++; if (obs_pulses != 1) begin bad++; $display("FAIL wl_pulses: got %0d want 1", obs_pulses); end
    total++; if (obs_wstrb !== 4'b0000 || obs_addr !== 32'h100) begin bad++; $display("FAIL wl_bus: got wstrb=%b addr=%h want 0000/00000100", obs_wstrb, obs_addr); end
    total++; if (obs_rdata !== 32'hDEAD_BEEF || obs_err !== 1'b0) begin bad++; $display("FAIL wl_resp: got %h err=%b want deadbeef/0", obs_rdata, obs_err); end
    total++; if (obs_lat != 3) begin bad++; $display("FAIL wl_latency: got %0d want 3", obs_lat); end
  endtask

  task automatic test_byte_store;
    run_txn(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5, 32'h1234_5678, 2, 0);
    total++; if (obs_wstrb !== 4'b1000) begin bad++; $display("FAIL bs_wstrb: got %b want 1000", obs_wstrb); end
    total++; if (obs_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL bs_wdata: got %h want a5a5a5a5", obs_wdata); end
    total++; if (obs_rdata !== 32'd0 || obs_err !== 1'b0) begin bad++; $display("FAIL bs_resp: got %h err=%b want 0/0", obs_rdata, obs_err); end
  endtask

  task automatic test_half_load;
    run_txn(1'b0, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h8001_1234, 1, 0);
    total++; if (obs_rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL hl_signed: got %h want ffff8001", obs_rdata); end
    run_txn(1'b0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8001_1234, 1, 0);
    total++; if (obs_rdata !== 32'h0000_8001) begin bad++; $display("FAIL hl_unsigned: got %h want 00008001", obs_rdata); end
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h5555_AAAA, 0, 0);
    total++; if (!got || obs_err !== 1'b1 || obs_rdata !== 32'd0) begin bad++; $display("FAIL to_resp: got resp=%b err=%b rdata=%h want 1/1/0", got, obs_err, obs_rdata); end
    total++; if (obs_lat != 2 + TO) begin bad++; $display("FAIL to_latency: got %0d want %0d", obs_lat, 2 + TO); end
    // Late ready while idle must be ignored
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL to_late_ready: got resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready); end
    run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 32'h0BAD_F00D, 2, 0);
    total++; if (obs_rdata !== 32'h0BAD_F00D || obs_err !== 1'b0 || obs_lat != 4) begin bad++; $display("FAIL to_recover: got %h err=%b lat=%0d want 0badf00d/0/4", obs_rdata, obs_err, obs_lat); end
    total++; if (obs_instr !== 1'b1) begin bad++; $display("FAIL to_instr: got %b want 1", obs_instr); end
    // Ready arriving on the timeout cycle wins
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h208, 32'h0, 32'h7777_0001, TO, 0);
    total++; if (obs_err !== 1'b0 || obs_rdata !== 32'h7777_0001 || obs_lat != 2 + TO) begin bad++; $display("FAIL to_ready_wins: got err=%b %h lat=%0d want 0/77770001/%0d", obs_err, obs_rdata, obs_lat, 2 + TO); end
  endtask

  task automatic test_misalign;
    int   exp_pulses;
    logic exp_err;
    logic [31:0] exp_rdata;
    exp_pulses = TRAP ? 0 : 1; exp_err = TRAP; exp_rdata = TRAP ? 32'd0 : 32'h1122_3344;
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h1122_3344, 1, 0);
    total++; if (obs_pulses != exp_pulses) begin bad++; $display("FAIL mis_pulses: got %0d want %0d", obs_pulses, exp_pulses); end
    total++; if (obs_err !== exp_err || obs_rdata !== exp_rdata) begin bad++; $display("FAIL mis_resp: got err=%b %h want %b/%h", obs_err, obs_rdata, exp_err, exp_rdata); end
    if (obs_pulses > 0) begin
      total++; if (obs_addr !== 32'h100) begin bad++; $display("FAIL mis_addr: got %h want 00000100", obs_addr); end
    end
  endtask

  task automatic test_resp_hold;
    run_txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h301, 32'h0, 32'h0000_9900, 3, 5);
    total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL hold_stable: got %b want 1", obs_stable); end
    total++; if (obs_rdata !== 32'hFFFF_FF99) begin bad++; $display("FAIL hold_rdata: got %h want ffffff99", obs_rdata); end
  endtask

  task automatic test_reserved;
    run_txn(1'b0, 1'b1, 2'd3, 1'b0, 32'h400, 32'h1234_5678, 32'h0, 1, 0);
    total++; if (obs_pulses != 0 || obs_err !== 1'b1 || obs_rdata !== 32'd0) begin bad++; $display("FAIL rsv: got pulses=%0d err=%b %h want 0/1/0", obs_pulses, obs_err, obs_rdata); end
    total++; if (obs_lat != 1) begin bad++; $display("FAIL rsv_latency: got %0d want 1", obs_lat); end
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h500;
    req_wdata = 32'hFEED_FACE; req_instr = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_valid !== 1'b0) begin bad++; $display("FAIL rmid_ctl: got req_ready=%b resp_valid=%b mem_valid=%b want 1/0/0", req_ready, resp_valid, mem_valid); end
    total++; if (mem_addr !== 32'd0 || mem_wstrb !== 4'd0 || mem_wdata !== 32'd0 || mem_instr !== 1'b0) begin bad++; $display("FAIL rmid_bus: got addr=%h wstrb=%b wdata=%h instr=%b want 0", mem_addr, mem_wstrb, mem_wdata, mem_instr); end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ignore: got resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_random;
    logic        w, u, ins, rej;
    logic [1:0]  sz;
    logic [31:0] a, wd, md, ea, ewd, erd;
    logic [3:0]  es;
    int          d, r, exp_lat;
    logic        exp_err;
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom); u = 1'($urandom); ins = 1'($urandom); sz = 2'($urandom);
      a = $urandom; wd = $urandom; md = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) d = 0;
      else if (r == 1) d = TO + $urandom_range(0, 2);
      else d = $urandom_range(1, TO);
      model(w, sz, u, a, wd, md, rej, ea, ewd, erd, es);
      if (rej) begin exp_lat = 1; exp_err = 1'b1; end
      else if (d >= 1 && d <= TO) begin exp_lat = 2 + d; exp_err = 1'b0; end
      else begin exp_lat = 2 + TO; exp_err = 1'b1; end
      if (exp_err) erd = 32'd0;
      run_txn(ins, w, sz, u, a, wd, md, d, $urandom_range(0, 2));
      total++; if (obs_acc !== 1'b1 || !got) begin bad++; $display("FAIL rnd%0d_handshake: got ready=%b resp=%b want 1/1", n, obs_acc, got); end
      total++; if (obs_err !== exp_err || obs_rdata !== erd) begin bad++; $display("FAIL rnd%0d_resp: got err=%b %h want %b/%h", n, obs_err, obs_rdata, exp_err, erd); end
      total++; if (obs_lat != exp_lat || obs_pulses != (rej ? 0 : 1)) begin bad++; $display("FAIL rnd%0d_timing: got lat=%0d pulses=%0d want %0d/%0d", n, obs_lat, obs_pulses, exp_lat, rej ? 0 : 1); end
      if (!rej) begin
        total++; if (obs_addr !== ea || obs_wstrb !== es || obs_wdata !== ewd || obs_instr !== ins) begin bad++; $display("FAIL rnd%0d_bus: got addr=%h wstrb=%b wdata=%h instr=%b want %h/%b/%h/%b", n, obs_addr, obs_wstrb, obs_wdata, obs_instr, ea, es, ewd, ins); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_byte_store;
    test_half_load;
    test_timeout;
    test_misalign;
    test_resp_hold;
    test_reserved;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
